// File: rtl/vend_change_dispenser.sv
// Vending core: accumulates coins, strobes dispense once credit reaches PRICE,
// then pays back any remainder one coin at a time over a valid/ack handshake.
module vend_change_dispenser #(
  parameter int WIDTH = 8,
  parameter int PRICE = 75
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             coin_valid,
  input  logic [1:0]       coin_code,
  input  logic             cancel,
  output logic [WIDTH-1:0] credit,
  output logic             dispense,
  output logic             change_valid,
  output logic [1:0]       change_coin,
  input  logic             change_ack,
  output logic             reject,
  output logic             busy
);

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    VEND    = 2'd1,
    CHANGE  = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] PRICE_W    = WIDTH'(PRICE);
  localparam logic [WIDTH:0]   CREDIT_MAX = {1'b0, {WIDTH{1'b1}}};

  state_t           state_q, state_d;
  logic [WIDTH-1:0] credit_q, credit_d;
  logic             dispense_q, dispense_d;
  logic             change_valid_q, change_valid_d;
  logic [1:0]       change_coin_q, change_coin_d;
  logic             reject_q, reject_d;
  logic             busy_q, busy_d;
  logic [WIDTH:0]   coin_sum;

  function automatic logic [WIDTH-1:0] coin_value(input logic [1:0] code);
    logic [WIDTH-1:0] v;
    case (code)
      2'b00:   v = WIDTH'(5);
      2'b01:   v = WIDTH'(10);
      2'b10:   v = WIDTH'(25);
      default: v = '0;
    endcase
    return v;
  endfunction

  function automatic logic [1:0] largest_coin(input logic [WIDTH-1:0] c);
    logic [1:0] code;
    if (c >= WIDTH'(25))      code = 2'b10;
    else if (c >= WIDTH'(10)) code = 2'b01;
    else                      code = 2'b00;
    return code;
  endfunction

  // One extra bit so a coin pushing credit past the register range is caught
  assign coin_sum = {1'b0, credit_q} + {1'b0, coin_value(coin_code)};

  always_comb begin
    state_d  = state_q;
    credit_d = credit_q;
    reject_d = 1'b0;

    unique case (state_q)
      COLLECT: begin
        if (coin_valid) begin
          if (coin_code == 2'b11 || coin_sum > CREDIT_MAX) reject_d = 1'b1;
          else                                            credit_d = coin_sum[WIDTH-1:0];
        end
        // Refund wins over vend when both apply on the same edge
        if (cancel && credit_d != '0)   state_d = CHANGE;
        else if (!(credit_d < PRICE_W)) state_d = VEND;
      end
      VEND: begin
        reject_d = coin_valid;
        credit_d = credit_q - PRICE_W;
        state_d  = (credit_d != '0) ? CHANGE : COLLECT;
      end
      CHANGE: begin
        reject_d = coin_valid;
        if (change_ack) begin
          credit_d = credit_q - coin_value(change_coin_q);
          if (credit_d == '0) state_d = COLLECT;
        end
      end
      default: state_d = COLLECT;
    endcase

    // Outputs are precomputed from the next state so they register with it
    dispense_d     = (state_d == VEND);
    change_valid_d = (state_d == CHANGE);
    change_coin_d  = change_valid_d ? largest_coin(credit_d) : 2'b00;
    busy_d         = (state_d != COLLECT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= COLLECT;
      credit_q       <= '0;
      dispense_q     <= 1'b0;
      change_valid_q <= 1'b0;
      change_coin_q  <= 2'b00;
      reject_q       <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      credit_q       <= credit_d;
      dispense_q     <= dispense_d;
      change_valid_q <= change_valid_d;
      change_coin_q  <= change_coin_d;
      reject_q       <= reject_d;
      busy_q         <= busy_d;
    end
  end

  assign credit       = credit_q;
  assign dispense     = dispense_q;
  assign change_valid = change_valid_q;
  assign change_coin  = change_coin_q;
  assign reject       = reject_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_vend_change_dispenser.sv
// Table-driven bench for vend_change_dispenser: each vector's expected
// outputs go through a scoreboard queue and are compared after the edge.
module tb_vend_change_dispenser;

  localparam int WIDTH = 8;
  localparam logic [1:0] N = 2'b00, D = 2'b01, Q = 2'b10, X = 2'b11;

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic             coinValid = 1'b0;
  logic [1:0]       coinCode = 2'b00;
  logic             cancel = 1'b0;
  logic             changeAck = 1'b0;
  logic [WIDTH-1:0] credit;
  logic             dispense;
  logic             changeValid;
  logic [1:0]       changeCoin;
  logic             reject;
  logic             busy;

  typedef struct {
    logic [WIDTH-1:0] credit;
    logic             dispense;
    logic             changeValid;
    logic [1:0]       changeCoin;
    logic             reject;
    logic             busy;
  } exp_t;

  typedef struct {
    logic       coinValid;
    logic [1:0] coinCode;
    logic       cancel;
    logic       ack;
    exp_t       exp;
  } vec_t;

  vec_t vecs[$];
  exp_t sbQueue[$];
  int   checkCount = 0;
  int   passCount = 0;
  int   stepNo = 0;

  vend_change_dispenser #(.WIDTH(WIDTH), .PRICE(75)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .coin_valid   (coinValid),
    .coin_code    (coinCode),
    .cancel       (cancel),
    .credit       (credit),
    .dispense     (dispense),
    .change_valid (changeValid),
    .change_coin  (changeCoin),
    .change_ack   (changeAck),
    .reject       (reject),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input logic cv, input logic [1:0] code, input logic cn,
                              input logic ack, input int cr, input logic dsp,
                              input logic vld, input logic [1:0] coin,
                              input logic rej, input logic bsy);
    vec_t v;
    v.coinValid           = cv;
    v.coinCode            = code;
    v.cancel              = cn;
    v.ack                 = ack;
    v.exp.credit          = WIDTH'(cr);
    v.exp.dispense        = dsp;
    v.exp.changeValid     = vld;
    v.exp.changeCoin      = coin;
    v.exp.reject          = rej;
    v.exp.busy            = bsy;
    return v;
  endfunction

  function automatic exp_t zeroExp();
    exp_t e;
    e.credit      = '0;
    e.dispense    = 1'b0;
    e.changeValid = 1'b0;
    e.changeCoin  = 2'b00;
    e.reject      = 1'b0;
    e.busy        = 1'b0;
    return e;
  endfunction

  task automatic cmp(input string name, input logic [WIDTH-1:0] act,
                     input logic [WIDTH-1:0] req);
    checkCount++;
    if (act !== req)
      $display("[TB] FAIL step %0d %s: got %0d, expected %0d", stepNo, name, act, req);
    else
      passCount++;
  endtask

  task automatic checkOutput();
    exp_t e;
    if (sbQueue.size() == 0) begin
      checkCount++;
      $display("[TB] FAIL step %0d scoreboard: got empty queue, expected an entry", stepNo);
      return;
    end
    e = sbQueue.pop_front();
    cmp("credit",       credit,                 e.credit);
    cmp("dispense",     WIDTH'(dispense),       WIDTH'(e.dispense));
    cmp("change_valid", WIDTH'(changeValid),    WIDTH'(e.changeValid));
    cmp("change_coin",  WIDTH'(changeCoin),     WIDTH'(e.changeCoin));
    cmp("reject",       WIDTH'(reject),         WIDTH'(e.reject));
    cmp("busy",         WIDTH'(busy),           WIDTH'(e.busy));
  endtask

  task automatic applyStimulus(input vec_t v);
    @(negedge clk);
    coinValid = v.coinValid;
    coinCode  = v.coinCode;
    cancel    = v.cancel;
    changeAck = v.ack;
    sbQueue.push_back(v.exp);
    @(posedge clk);
    #1;
    stepNo++;
    checkOutput();
  endtask

  task automatic runTable();
    foreach (vecs[i]) applyStimulus(vecs[i]);
    vecs.delete();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no completion, expected finish before time limit");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    // Asynchronous reset with no clock edge involved
    #1 rst_n = 1'b0;
    #1;
    sbQueue.push_back(zeroExp());
    checkOutput();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Three quarters vend exactly; cancel with zero credit is ignored
    vecs.push_back(mk(1, Q, 0, 0, 25, 0, 0, N, 0, 0));
    vecs.push_back(mk(1, Q, 0, 0, 50, 0, 0, N, 0, 0));
    vecs.push_back(mk(1, Q, 0, 0, 75, 1, 0, N, 0, 1));
    vecs.push_back(mk(0, N, 0, 0,  0, 0, 0, N, 0, 0));
    vecs.push_back(mk(0, N, 1, 0,  0, 0, 0, N, 0, 0));
    // Q Q D D D -> 80, nickel change; coin and cancel during VEND
    vecs.push_back(mk(1, Q, 0, 0, 25, 0, 0, N, 0, 0));
    vecs.push_back(mk(1, Q, 0, 0, 50, 0, 0, N, 0, 0));
    vecs.push_back(mk(1, D, 0, 0, 60, 0, 0, N, 0, 0));
    vecs.push_back(mk(1, D, 0, 0, 70, 0, 0, N, 0, 0));
    vecs.push_back(mk(1, D, 0, 0, 80, 1, 0, N, 0, 1));
    vecs.push_back(mk(1, N, 1, 0,  5, 0, 1, N, 1, 1));
    vecs.push_back(mk(0, N, 0, 0,  5, 0, 1, N, 0, 1));
    vecs.push_back(mk(0, N, 0, 1,  0, 0, 0, N, 0, 0));
    // Q D cancel: quarter held stable, then dime
    vecs.push_back(mk(1, Q, 0, 0, 25, 0, 0, N, 0, 0));
    vecs.push_back(mk(1, D, 0, 0, 35, 0, 0, N, 0, 0));
    vecs.push_back(mk(0, N, 1, 0, 35, 0, 1, Q, 0, 1));
    vecs.push_back(mk(0, N, 0, 0, 35, 0, 1, Q, 0, 1));
    vecs.push_back(mk(0, N, 1, 0, 35, 0, 1, Q, 0, 1));
    vecs.push_back(mk(0, N, 0, 0, 35, 0, 1, Q, 0, 1));
    vecs.push_back(mk(0, N, 0, 1, 10, 0, 1, D, 0, 1));
    vecs.push_back(mk(0, N, 0, 1,  0, 0, 0, N, 0, 0));
    // Invalid coin in COLLECT, quarter during CHANGE
    vecs.push_back(mk(1, X, 0, 0,  0, 0, 0, N, 1, 0));
    vecs.push_back(mk(0, N, 0, 0,  0, 0, 0, N, 0, 0));
    vecs.push_back(mk(1, D, 1, 0, 10, 0, 1, D, 0, 1));
    vecs.push_back(mk(1, Q, 0, 0, 10, 0, 1, D, 1, 1));
    vecs.push_back(mk(0, N, 0, 0, 10, 0, 1, D, 0, 1));
    vecs.push_back(mk(0, N, 0, 1,  0, 0, 0, N, 0, 0));
    // Third quarter together with cancel: refund beats vend
    vecs.push_back(mk(1, Q, 0, 0, 25, 0, 0, N, 0, 0));
    vecs.push_back(mk(1, Q, 0, 0, 50, 0, 0, N, 0, 0));
    vecs.push_back(mk(1, Q, 1, 0, 75, 0, 1, Q, 0, 1));
    vecs.push_back(mk(0, N, 0, 1, 50, 0, 1, Q, 0, 1));
    vecs.push_back(mk(0, N, 0, 1, 25, 0, 1, Q, 0, 1));
    vecs.push_back(mk(0, N, 0, 1,  0, 0, 0, N, 0, 0));
    // Stray ack in COLLECT, then reach CHANGE with credit 15
    vecs.push_back(mk(1, N, 0, 1,  5, 0, 0, N, 0, 0));
    vecs.push_back(mk(1, D, 0, 0, 15, 0, 0, N, 0, 0));
    vecs.push_back(mk(0, N, 1, 0, 15, 0, 1, D, 0, 1));
    runTable();

    // Reset mid-CHANGE clears outputs without waiting for a clock edge
    #2 rst_n = 1'b0;
    #1;
    stepNo++;
    sbQueue.push_back(zeroExp());
    checkOutput();
    @(negedge clk);
    rst_n = 1'b1;

    vecs.push_back(mk(0, N, 0, 1,  0, 0, 0, N, 0, 0));
    vecs.push_back(mk(1, Q, 0, 0, 25, 0, 0, N, 0, 0));
    vecs.push_back(mk(1, Q, 0, 0, 50, 0, 0, N, 0, 0));
    vecs.push_back(mk(1, Q, 0, 0, 75, 1, 0, N, 0, 1));
    vecs.push_back(mk(0, N, 0, 0,  0, 0, 0, N, 0, 0));
    runTable();

    if (sbQueue.size() != 0) begin
      checkCount++;
      $display("[TB] FAIL drain: got %0d leftover entries, expected 0", sbQueue.size());
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/vend_change_dispenser.md
Name: vend_change_dispenser

Overview:
Sequential vending core that pairs with the team's credit-vs-price comparator. It accumulates inserted coins and evaluates "credit < PRICE" internally each cycle. It issues a one-cycle dispense strobe once credit reaches PRICE, then returns any remainder coin-by-coin over a valid/ack handshake. It sits between the coin acceptor front-end and the product/change actuators of the soda machine.

Parameters:
WIDTH, 8, credit register width in cents.
PRICE, 75, product price in cents. Must be a multiple of 5, nonzero, and below 2^WIDTH-25.

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
coin_valid  input  1  coin present this cycle.
coin_code  input  2  00=nickel(5), 01=dime(10), 10=quarter(25), 11=invalid.
cancel  input  1  refund request, level-sampled.
credit  output  WIDTH  current credit in cents.
dispense  output  1  one-cycle product release strobe.
change_valid  output  1  change coin offered.
change_coin  output  2  coin offered: 00=nickel, 01=dime, 10=quarter.
change_ack  input  1  change actuator accepted offered coin.
reject  output  1  one-cycle pulse: coin returned unaccepted.
busy  output  1  high whenever state is not COLLECT.

Behaviour:
- Reset (async assert, sync release):
  - state=COLLECT, credit=0, dispense=0, change_valid=0, change_coin=00, reject=0, busy=0.
  - Reset mid-VEND or mid-CHANGE discards credit; no further dispense or change is issued.
- All outputs are registered.
- State COLLECT:
  - coin_valid with code 00/01/10: credit <= credit+value at this edge.
  - coin_valid with code 11: reject=1 next cycle; credit unchanged.
  - Next-state after applying the coin, evaluated on the new credit:
    - cancel=1 and new credit>0 -> CHANGE (refund; cancel beats vend).
    - else new credit >= PRICE -> VEND.
    - else stay in COLLECT.
  - cancel with credit=0 and no coin: ignored.
- State VEND (exactly one cycle):
  - dispense=1 for this cycle only.
  - credit <= credit-PRICE at the exiting edge.
  - Exit to CHANGE if the remainder is >0, else to COLLECT.
- State CHANGE:
  - change_valid=1. change_coin = largest coin <= credit (quarter if >=25, dime if >=10, else nickel).
  - change_coin and credit must stay stable while change_valid=1 and change_ack=0.
  - On change_ack=1: credit <= credit-coin value at that edge.
    - If the result is 0: change_valid=0 next cycle; go to COLLECT.
    - Else: present the next coin in the following cycle (no idle cycle).
  - change_ack while change_valid=0 is ignored.
- Coins arriving in VEND or CHANGE: reject=1 next cycle; credit unchanged.
- cancel in VEND or CHANGE: ignored.
- Arithmetic:
  - Unsigned, WIDTH bits. The comparison is a strict unsigned less-than on the full width.
  - A coin that would make credit exceed 2^WIDTH-1 is rejected (reject pulse, no add).
  - Credit never underflows; the FSM only subtracts values <= credit.
- Latency: the edge that samples the completing coin enters VEND; dispense is high in the next cycle; the first change coin is offered in the cycle after that.

Test Plan:
1. Quarter x3 in consecutive cycles -> credit 25, 50, 75; dispense high exactly one cycle; credit 0 afterwards; change_valid never asserts; busy high 1 cycle.
2. Q, Q, D, D, D -> credit reaches 80; dispense pulse; then change_valid with change_coin=00 (nickel); ack -> credit 0, change_valid low, back in COLLECT.
3. Q, D, then cancel; hold change_ack low 3 cycles -> change_coin=10 stable with credit 35; ack -> change_coin=01 next cycle; ack -> done. No dispense.
4. Coin code 11 in COLLECT, plus a quarter during CHANGE -> reject pulses one cycle each; credit unchanged in both cases.
5. Q, Q, then the third Q with cancel in the same cycle -> no dispense; refund of three quarters via handshake; credit 75 -> 50 -> 25 -> 0.
6. Assert rst_n low during CHANGE with credit 15 -> all outputs zero immediately (asynchronous); after release no change_valid; three quarters then vend normally.
